// File: rtl/image_stream_packer.sv
// image_stream_packer
//   Receives a frame of pixel bytes from a UART receiver and packs them,
//   little-endian, into MEM_WIDTH-bit words for a frame-buffer write port.
//   The host is acknowledged with 8'h06 every ACK_CHUNK bytes and at the end
//   of the frame. Consecutive frames alternate between two banks of WORDS
//   words each. A transfer that stalls in RECV for TIMEOUT_CYCLES cycles is
//   aborted with a NAK (8'h15). TIMEOUT_CYCLES = 0 disables the timeout.
//
// Ports
//   clk             system clock
//   reset           asynchronous, active-low reset
//   rx_data         received byte, valid while rx_ready is high
//   rx_ready        one-cycle strobe per received byte
//   tx_busy         transmitter busy
//   mem_ready       memory write accepted (sampled at posedge while mem_req)
//   tx_data         byte to transmit
//   tx_ready        one-cycle transmit strobe
//   mem_req         memory write request
//   mem_addr        word address (active_bank*WORDS + word index)
//   mem_in          write data
//   streaming_ended one-cycle pulse at frame completion
//   active_bank     bank currently being filled
//   timeout_err     one-cycle pulse on abort
module image_stream_packer #(
    parameter int IMAGE_BUF_X     = 4,
    parameter int IMAGE_BUF_Y     = 3,
    parameter int BYTES_PER_PIXEL = 2,
    parameter int MEM_WIDTH       = 16,
    parameter int ACK_CHUNK       = 2,
    parameter int TIMEOUT_CYCLES  = 1000000,
    parameter int ADDR_WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_ready,
    input  logic                  tx_busy,
    input  logic                  mem_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_ready,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [MEM_WIDTH-1:0]  mem_in,
    output logic                  streaming_ended,
    output logic                  active_bank,
    output logic                  timeout_err
);

    localparam int FRAME_BYTES = IMAGE_BUF_X * IMAGE_BUF_Y * BYTES_PER_PIXEL;
    localparam int BPW         = MEM_WIDTH / 8;
    localparam int WORDS       = (FRAME_BYTES + BPW - 1) / BPW;

    localparam int BYTE_W  = $clog2(FRAME_BYTES) + 1;
    localparam int WORD_W  = $clog2(WORDS) + 1;
    localparam int CHUNK_W = $clog2(ACK_CHUNK) + 1;
    localparam int LANE_W  = $clog2(BPW) + 1;
    localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1) + 1;

    localparam logic [7:0]            START_BYTE = 8'h06;
    localparam logic [7:0]            ACK_BYTE   = 8'h06;
    localparam logic [7:0]            NAK_BYTE   = 8'h15;
    localparam logic [ADDR_WIDTH-1:0] BANK1_BASE = ADDR_WIDTH'(WORDS);

    if ((MEM_WIDTH % 8) != 0 || (ACK_CHUNK % (MEM_WIDTH / 8)) != 0) begin : g_bad_params
        $error("MEM_WIDTH must be a multiple of 8 and ACK_CHUNK a multiple of MEM_WIDTH/8");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_ACK_TX,
        S_DONE,
        S_ABORT
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [BYTE_W-1:0]    byte_cnt;
    logic [WORD_W-1:0]    word_idx;
    logic [CHUNK_W-1:0]   chunk_cnt;
    logic [LANE_W-1:0]    lane;
    logic [TO_W-1:0]      timeout_cnt;
    logic [MEM_WIDTH-1:0] pack;
    logic                 abort_flagged;

    logic is_start;
    logic frame_done;
    logic last_byte;
    logic word_full;
    logic timed_out;

    assign is_start   = rx_ready && (rx_data == START_BYTE);
    assign frame_done = (byte_cnt == BYTE_W'(FRAME_BYTES));
    assign last_byte  = (byte_cnt == BYTE_W'(FRAME_BYTES - 1));
    assign word_full  = (lane == LANE_W'(BPW - 1));
    assign timed_out  = (TIMEOUT_CYCLES != 0) && (timeout_cnt == TO_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            byte_cnt      <= '0;
            word_idx      <= '0;
            chunk_cnt     <= '0;
            lane          <= '0;
            timeout_cnt   <= '0;
            pack          <= '0;
            active_bank   <= 1'b0;
            abort_flagged <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state         <= state_next;
            // Marks that the abort pulse has already been given while ABORT waits on tx_busy.
            abort_flagged <= (state == S_ABORT);
            case (state)
                S_IDLE: begin
                    if (is_start) begin
                        byte_cnt    <= '0;
                        word_idx    <= '0;
                        chunk_cnt   <= '0;
                        lane        <= '0;
                        timeout_cnt <= '0;
                        pack        <= '0;
                    end
                end
                S_RECV: begin
                    if (rx_ready) begin
                        for (int i = 0; i < BPW; i++) begin
                            if (lane == LANE_W'(i)) pack[8*i +: 8] <= rx_data;
                        end
                        byte_cnt    <= byte_cnt + 1'b1;
                        chunk_cnt   <= chunk_cnt + 1'b1;
                        lane        <= lane + 1'b1;
                        timeout_cnt <= '0;
                    end else if (timeout_cnt != TO_W'(TIMEOUT_CYCLES)) begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end
                S_WRITE: begin
                    if (mem_ready) begin
                        word_idx <= word_idx + 1'b1;
                        pack     <= '0;
                        lane     <= '0;
                    end
                end
                S_ACK_TX: begin
                    if (!tx_busy) begin
                        chunk_cnt <= '0;
                        // Toggle on entry to DONE so the new bank is visible with streaming_ended.
                        if (frame_done) active_bank <= ~active_bank;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a latch.
        state_next      = state;
        tx_data         = '0;
        tx_ready        = 1'b0;
        mem_req         = 1'b0;
        mem_addr        = '0;
        mem_in          = '0;
        streaming_ended = 1'b0;
        timeout_err     = 1'b0;
        case (state)
            S_IDLE: begin
                if (is_start) state_next = S_RECV;
            end
            S_RECV: begin
                if (rx_ready) begin
                    if (word_full || last_byte) state_next = S_WRITE;
                end else if (timed_out) begin
                    state_next = S_ABORT;
                end
            end
            S_WRITE: begin
                mem_req  = 1'b1;
                mem_addr = (active_bank ? BANK1_BASE : '0) + ADDR_WIDTH'(word_idx);
                mem_in   = pack;
                if (mem_ready) begin
                    if (chunk_cnt == CHUNK_W'(ACK_CHUNK) || frame_done) state_next = S_ACK_TX;
                    else                                                  state_next = S_RECV;
                end
            end
            S_ACK_TX: begin
                tx_data = ACK_BYTE;
                if (!tx_busy) begin
                    tx_ready   = 1'b1;
                    state_next = frame_done ? S_DONE : S_RECV;
                end
            end
            S_DONE: begin
                streaming_ended = 1'b1;
                state_next      = S_IDLE;
            end
            S_ABORT: begin
                tx_data     = NAK_BYTE;
                timeout_err = !abort_flagged;
                if (!tx_busy) begin
                    tx_ready   = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_image_stream_packer.sv
// Directed testbench for image_stream_packer: default geometry instance
// (24 bytes, 12 x 16-bit words, TIMEOUT_CYCLES=16) plus a partial-word
// instance (3 bytes into one 32-bit word).
module tb_image_stream_packer;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_busy;
    logic        mem_ready;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [15:0] mem_in;
    logic        streaming_ended;
    logic        active_bank;
    logic        timeout_err;

    logic [7:0]  p_rx_data;
    logic        p_rx_ready;
    logic        p_tx_busy;
    logic        p_mem_ready;
    logic [7:0]  p_tx_data;
    logic        p_tx_ready;
    logic        p_mem_req;
    logic [31:0] p_mem_addr;
    logic [31:0] p_mem_in;
    logic        p_streaming_ended;
    logic        p_active_bank;
    logic        p_timeout_err;

    int checks = 0;
    int passed = 0;

    int ack_cnt     = 0;
    int nak_cnt     = 0;
    int bad_tx      = 0;
    int busy_viol   = 0;
    int terr_cnt    = 0;
    int ended_cnt   = 0;
    int ack_at_end  = 0;
    int hold_err    = 0;
    logic [31:0] stall_addr = 32'hFFFF_FFFF;
    logic [31:0] wr_addr[$];
    logic [15:0] wr_data[$];

    image_stream_packer #(
        .IMAGE_BUF_X(4), .IMAGE_BUF_Y(3), .BYTES_PER_PIXEL(2), .MEM_WIDTH(16),
        .ACK_CHUNK(2), .TIMEOUT_CYCLES(16), .ADDR_WIDTH(32)
    ) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_busy(tx_busy), .mem_ready(mem_ready), .tx_data(tx_data),
        .tx_ready(tx_ready), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_in(mem_in), .streaming_ended(streaming_ended),
        .active_bank(active_bank), .timeout_err(timeout_err)
    );

    image_stream_packer #(
        .IMAGE_BUF_X(3), .IMAGE_BUF_Y(1), .BYTES_PER_PIXEL(1), .MEM_WIDTH(32),
        .ACK_CHUNK(4), .TIMEOUT_CYCLES(0), .ADDR_WIDTH(32)
    ) dut_p (
        .clk(clk), .reset(reset), .rx_data(p_rx_data), .rx_ready(p_rx_ready),
        .tx_busy(p_tx_busy), .mem_ready(p_mem_ready), .tx_data(p_tx_data),
        .tx_ready(p_tx_ready), .mem_req(p_mem_req), .mem_addr(p_mem_addr),
        .mem_in(p_mem_in), .streaming_ended(p_streaming_ended),
        .active_bank(p_active_bank), .timeout_err(p_timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: raises mem_ready one cycle after mem_req (five on stall_addr)
    // and checks that the request stays stable while waiting.
    initial begin : mem_responder
        int wait_cycles;
        int delay;
        logic [31:0] held_addr;
        logic [15:0] held_data;
        wait_cycles = 0;
        held_addr   = '0;
        held_data   = '0;
        mem_ready   = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                if (wait_cycles == 0) begin
                    held_addr = mem_addr;
                    held_data = mem_in;
                end else if (mem_addr !== held_addr || mem_in !== held_data) begin
                    hold_err++;
                end
                delay = (mem_addr === stall_addr) ? 5 : 1;
                if (wait_cycles >= delay) begin
                    mem_ready = 1'b1;
                    wr_addr.push_back(mem_addr);
                    wr_data.push_back(mem_in);
                    wait_cycles = 0;
                end else begin
                    mem_ready = 1'b0;
                    wait_cycles++;
                end
            end else begin
                mem_ready   = 1'b0;
                wait_cycles = 0;
            end
        end
    end

    // Transmit / status monitor.
    initial begin : tx_monitor
        forever begin
            @(negedge clk);
            if (tx_ready === 1'b1) begin
                if (tx_busy === 1'b1) busy_viol++;
                if (tx_data === 8'h06)      ack_cnt++;
                else if (tx_data === 8'h15) nak_cnt++;
                else                        bad_tx++;
            end
            if (timeout_err === 1'b1) terr_cnt++;
            if (streaming_ended === 1'b1) begin
                ended_cnt++;
                ack_at_end = ack_cnt;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: time limit reached, checks so far %0d/%0d", passed, checks);
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
    endtask

    task automatic p_send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        p_rx_data  = b;
        p_rx_ready = 1'b1;
        @(posedge clk);
        #1;
        p_rx_ready = 1'b0;
    endtask

    task automatic wait_ack(input int target);
        for (int c = 0; c < 100 && ack_cnt < target; c++) @(negedge clk);
    endtask

    task automatic wait_ended(input int target);
        for (int c = 0; c < 100 && ended_cnt < target; c++) @(negedge clk);
    endtask

    // Sends start + bytes 0..23 and checks the resulting writes, ACKs and end pulse.
    task automatic run_frame(input logic [31:0] base, input bit stalls,
                             input logic exp_bank, input string tag);
        int a0, e0, n0, t0;
        logic [15:0] exp_word;
        wr_addr.delete();
        wr_data.delete();
        a0 = ack_cnt; e0 = ended_cnt; n0 = nak_cnt; t0 = terr_cnt;
        hold_err   = 0;
        stall_addr = stalls ? base + 32'd3 : 32'hFFFF_FFFF;
        send_byte(8'h06);
        for (int i = 0; i < 24; i++) begin
            if (stalls && i == 11) tx_busy = 1'b1;
            send_byte(8'(i));
            if (stalls && i == 7) begin
                send_byte(8'hEE);
                send_byte(8'hEE);
                checks++;
                if (mem_req !== 1'b1 || mem_addr !== base + 32'd3 || ack_cnt !== a0 + 3)
                    $display("FAIL %s mem_stall: req=%b addr=%0d acks=%0d, required req=1 addr=%0d acks=%0d",
                             tag, mem_req, mem_addr, ack_cnt - a0, base + 32'd3, 3);
                else passed++;
            end
            if (stalls && i == 11) begin
                repeat (6) @(posedge clk);
                #1;
                checks++;
                if (ack_cnt !== a0 + 5 || tx_ready !== 1'b0)
                    $display("FAIL %s tx_busy_hold: acks=%0d tx_ready=%b, required acks=5 tx_ready=0",
                             tag, ack_cnt - a0, tx_ready);
                else passed++;
                tx_busy = 1'b0;
            end
            if (i % 2 == 1) begin
                wait_ack(a0 + (i + 1) / 2);
                checks++;
                if (ack_cnt !== a0 + (i + 1) / 2)
                    $display("FAIL %s ack_word%0d: acks=%0d, required %0d",
                             tag, i / 2, ack_cnt - a0, (i + 1) / 2);
                else passed++;
            end
        end
        wait_ended(e0 + 1);
        repeat (3) @(negedge clk);
        stall_addr = 32'hFFFF_FFFF;
        checks++;
        if (wr_addr.size() != 12)
            $display("FAIL %s write_count: got %0d, required 12", tag, wr_addr.size());
        else passed++;
        for (int k = 0; k < 12 && k < wr_addr.size(); k++) begin
            exp_word = {8'(2 * k + 1), 8'(2 * k)};
            checks++;
            if (wr_addr[k] !== base + 32'(k) || wr_data[k] !== exp_word)
                $display("FAIL %s write%0d: addr=%0d data=%h, required addr=%0d data=%h",
                         tag, k, wr_addr[k], wr_data[k], base + 32'(k), exp_word);
            else passed++;
        end
        checks++;
        if (ack_cnt !== a0 + 12 || nak_cnt !== n0 || bad_tx !== 0 || busy_viol !== 0)
            $display("FAIL %s tx_totals: acks=%0d naks=%0d bad=%0d busy_viol=%0d, required 12/0/0/0",
                     tag, ack_cnt - a0, nak_cnt - n0, bad_tx, busy_viol);
        else passed++;
        checks++;
        if (ended_cnt !== e0 + 1 || ack_at_end !== a0 + 12)
            $display("FAIL %s end_pulse: pulses=%0d acks_before=%0d, required 1 and 12",
                     tag, ended_cnt - e0, ack_at_end - a0);
        else passed++;
        checks++;
        if (active_bank !== exp_bank || terr_cnt !== t0 || hold_err !== 0)
            $display("FAIL %s bank_hold: bank=%b timeouts=%0d hold_err=%0d, required bank=%b 0 0",
                     tag, active_bank, terr_cnt - t0, hold_err, exp_bank);
        else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rx_data = '0; rx_ready = 1'b0; tx_busy = 1'b0;
        p_rx_data = '0; p_rx_ready = 1'b0; p_tx_busy = 1'b0; p_mem_ready = 1'b1;
        #3 reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== 32'd0 || mem_in !== 16'd0)
            $display("FAIL reset_mem: req=%b addr=%h data=%h, required all 0", mem_req, mem_addr, mem_in);
        else passed++;
        checks++;
        if (tx_ready !== 1'b0 || tx_data !== 8'd0)
            $display("FAIL reset_tx: tx_ready=%b tx_data=%h, required 0", tx_ready, tx_data);
        else passed++;
        checks++;
        if (streaming_ended !== 1'b0 || timeout_err !== 1'b0 || active_bank !== 1'b0)
            $display("FAIL reset_status: ended=%b terr=%b bank=%b, required 0", streaming_ended, timeout_err, active_bank);
        else passed++;
        checks++;
        if (p_mem_req !== 1'b0 || p_mem_in !== 32'd0 || p_active_bank !== 1'b0)
            $display("FAIL reset_partial: req=%b data=%h bank=%b, required 0", p_mem_req, p_mem_in, p_active_bank);
        else passed++;
        reset = 1'b1;
    endtask

    task automatic test_frame();
        // Non-start bytes in IDLE must be ignored.
        send_byte(8'h41);
        send_byte(8'h00);
        run_frame(32'd0, 1'b0, 1'b1, "frame1");
    endtask

    task automatic test_second_frame();
        run_frame(32'd12, 1'b0, 1'b0, "frame2");
    endtask

    task automatic test_timeout();
        int a0, n0, t0, c;
        bit seen;
        a0 = ack_cnt; n0 = nak_cnt; t0 = terr_cnt;
        send_byte(8'h06);
        for (int i = 0; i < 5; i++) begin
            send_byte(8'(i));
            if (i % 2 == 1) wait_ack(a0 + (i + 1) / 2);
        end
        seen = 1'b0;
        c = 0;
        while (!seen && c < 60) begin
            @(negedge clk);
            c++;
            if (timeout_err === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || c <= 16 || c > 20)
            $display("FAIL timeout_delay: seen=%b after %0d cycles, required seen=1 within 17..20", seen, c);
        else passed++;
        for (int k = 0; k < 40 && nak_cnt < n0 + 1; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        checks++;
        if (nak_cnt !== n0 + 1 || terr_cnt !== t0 + 1)
            $display("FAIL timeout_nak: naks=%0d timeout_pulses=%0d, required 1 and 1", nak_cnt - n0, terr_cnt - t0);
        else passed++;
        checks++;
        if (active_bank !== 1'b0 || ack_cnt !== a0 + 2)
            $display("FAIL timeout_bank: bank=%b acks=%0d, required bank=0 acks=2", active_bank, ack_cnt - a0);
        else passed++;
    endtask

    task automatic test_stalls();
        run_frame(32'd0, 1'b1, 1'b1, "after_timeout_stalls");
    endtask

    task automatic test_reset_mid_frame();
        int a0, n0;
        a0 = ack_cnt; n0 = nak_cnt;
        send_byte(8'h06);
        for (int i = 0; i < 10; i++) begin
            send_byte(8'(i));
            if (i % 2 == 1 && i < 9) wait_ack(a0 + (i + 1) / 2);
        end
        #2;
        checks++;
        if (mem_req !== 1'b1 || active_bank !== 1'b1)
            $display("FAIL pre_reset: req=%b bank=%b, required req=1 bank=1", mem_req, active_bank);
        else passed++;
        reset = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== 32'd0 || mem_in !== 16'd0 || tx_ready !== 1'b0 ||
            tx_data !== 8'd0 || streaming_ended !== 1'b0 || timeout_err !== 1'b0 || active_bank !== 1'b0)
            $display("FAIL async_reset: req=%b addr=%h data=%h txr=%b txd=%h end=%b terr=%b bank=%b, required all 0",
                     mem_req, mem_addr, mem_in, tx_ready, tx_data, streaming_ended, timeout_err, active_bank);
        else passed++;
        repeat (3) @(negedge clk);
        checks++;
        if (ack_cnt !== a0 + 4 || nak_cnt !== n0)
            $display("FAIL reset_no_tx: acks=%0d naks=%0d, required 4 and 0", ack_cnt - a0, nak_cnt - n0);
        else passed++;
        reset = 1'b1;
        run_frame(32'd0, 1'b0, 1'b1, "after_reset");
    endtask

    task automatic test_partial_word();
        int writes, acks, ends, acks_at_end;
        logic [31:0] got_addr, got_data;
        writes = 0; acks = 0; ends = 0; acks_at_end = 0;
        got_addr = '1; got_data = '1;
        p_send_byte(8'h06);
        for (int i = 0; i < 3; i++) p_send_byte(8'(i));
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (p_mem_req === 1'b1 && p_mem_ready === 1'b1) begin
                writes++;
                got_addr = p_mem_addr;
                got_data = p_mem_in;
            end
            if (p_tx_ready === 1'b1 && p_tx_data === 8'h06) acks++;
            if (p_streaming_ended === 1'b1) begin
                ends++;
                acks_at_end = acks;
            end
        end
        checks++;
        if (writes != 1 || got_addr !== 32'd0 || got_data !== 32'h0002_0100)
            $display("FAIL partial_write: writes=%0d addr=%h data=%h, required 1 0 00020100", writes, got_addr, got_data);
        else passed++;
        checks++;
        if (acks != 1 || ends != 1 || acks_at_end != 1 || p_active_bank !== 1'b1)
            $display("FAIL partial_end: acks=%0d ends=%0d acks_before=%0d bank=%b, required 1 1 1 1",
                     acks, ends, acks_at_end, p_active_bank);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_frame();
        test_second_frame();
        test_timeout();
        test_stalls();
        test_reset_mid_frame();
        test_partial_word();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/image_stream_packer.md
Name: image_stream_packer

Overview:
- Parametrised successor to the byte-per-word image streaming controller.
- Receives a frame of pixel bytes from the UART receiver and packs them into MEM_WIDTH-bit words for the memory writer.
- Acknowledges the host every ACK_CHUNK bytes and ping-pongs between two frame banks.
- Aborts a stalled transfer with a NAK after a configurable timeout. Sits between uart_rx/uart_tx and the frame-buffer memory port.

Parameters:
- IMAGE_BUF_X, 4: frame width in pixels.
- IMAGE_BUF_Y, 3: frame height in pixels.
- BYTES_PER_PIXEL, 2: bytes per pixel. FRAME_BYTES = X*Y*BYTES_PER_PIXEL.
- MEM_WIDTH, 16: memory word width in bits.
  - Must be a multiple of 8.
  - BPW = MEM_WIDTH/8.
  - WORDS = ceil(FRAME_BYTES/BPW).
- ACK_CHUNK, 2: bytes per ACK. Must be a multiple of BPW.
- TIMEOUT_CYCLES, 1000000: idle cycles in RECV before abort. 0 disables the timeout.
- ADDR_WIDTH, 32: memory address width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte, valid while rx_ready is high.
- rx_ready  in  1  one-cycle strobe per received byte.
- tx_busy  in  1  transmitter busy.
- mem_ready  in  1  memory write accepted.
- tx_data  out  8  byte to transmit.
- tx_ready  out  1  one-cycle transmit strobe.
- mem_req  out  1  memory write request.
- mem_addr  out  ADDR_WIDTH  word address.
- mem_in  out  MEM_WIDTH  write data.
- streaming_ended  out  1  one-cycle pulse at frame completion.
- active_bank  out  1  bank currently being filled.
- timeout_err  out  1  one-cycle pulse on abort.

Behaviour:
- Reset (reset low, asynchronous):
  - All outputs drive 0 and active_bank = 0.
  - State goes to IDLE; byte, word, chunk and timeout counters clear; pack register clears.
  - Reset mid-frame discards the partial frame; no ACK or NAK is sent.
- States: IDLE, RECV, WRITE, ACK_TX, DONE, ABORT.
- IDLE:
  - rx_ready with rx_data == 8'h06 (start) moves to RECV, clearing counters and pack register.
  - Any other byte is ignored.
- RECV:
  - Each rx_ready cycle accepts one byte, little-endian: byte n of a word lands in bits [8n+7:8n].
  - The byte counter increments and the timeout counter clears.
  - Go to WRITE when BPW bytes are packed or the last frame byte arrives.
  - On the last byte, unfilled high bytes are zero.
- WRITE:
  - mem_req = 1, mem_addr = active_bank*WORDS + word_idx, mem_in = pack register.
  - mem_req, mem_addr and mem_in hold stable until mem_ready is sampled high at a posedge.
  - mem_req drops on the following cycle.
  - word_idx increments and the pack register clears.
  - Next state:
    - ACK_TX if chunk bytes == ACK_CHUNK or the frame is complete.
    - Otherwise back to RECV.
- ACK_TX:
  - tx_data = 8'h06.
  - Wait while tx_busy is high. tx_ready pulses for exactly one cycle in the first cycle tx_busy is low.
  - The chunk counter clears.
  - Next state is DONE if the frame is complete, otherwise RECV.
- DONE:
  - streaming_ended pulses for one cycle and active_bank toggles in the same cycle.
  - Next state is IDLE.
- ABORT (entered from RECV when the timeout counter reaches TIMEOUT_CYCLES and TIMEOUT_CYCLES != 0):
  - timeout_err pulses once.
  - Send NAK: tx_data = 8'h15, tx_ready follows the same tx_busy rule as ACK_TX.
  - Next state is IDLE; active_bank is unchanged.
  - The next frame rewrites the same bank from word 0.
- rx_ready strobes in WRITE, ACK_TX, DONE or ABORT are dropped; the host must wait for the ACK.
- The final ACK precedes the streaming_ended pulse.
- word_idx never wraps within a frame; the bank offset provides the ping-pong.
- Counter widths: $clog2 of the respective maxima plus 1.
- Timeout saturates at TIMEOUT_CYCLES; it counts only in RECV.

Test Plan:
- Defaults (24 bytes, 12 words), tx_busy = 0, mem_ready = 1 one cycle after each mem_req:
  - Stimulus: start 0x06, then bytes 0..23.
  - Response: mem_addr 0..11 with mem_in[k] = {8'(2k+1), 8'(2k)}; 12 ACK (0x06) strobes; one streaming_ended pulse after the 12th ACK; active_bank = 1.
- Second frame immediately after the first, same data:
  - Response: mem_addr 12..23 with identical data; active_bank returns to 0.
- Partial final word, X=3, Y=1, BYTES_PER_PIXEL=1, MEM_WIDTH=32, ACK_CHUNK=4:
  - Stimulus: bytes 0,1,2.
  - Response: a single write with mem_addr 0, mem_in 32'h00020100; one ACK; streaming_ended.
- Memory and transmitter stalls:
  - Stimulus: mem_ready held low 5 cycles on word 3; extra rx_ready strobes during the stall.
  - Response: mem_req, mem_addr (3) and mem_in stay constant; stray strobes are dropped; no ACK until after the write.
  - Stimulus: tx_busy high for 4 cycles at ACK_TX.
  - Response: tx_ready stays low until tx_busy falls, then pulses exactly once.
- Timeout with TIMEOUT_CYCLES=16:
  - Stimulus: start plus 5 bytes, then silence.
  - Response: after 16 idle cycles, timeout_err pulses and a NAK (0x15) is sent; active_bank stays 0.
  - Follow-up: a new start plus 24 bytes writes mem_addr from 0.
- Reset mid-frame:
  - Stimulus: assert reset low asynchronously after byte 9.
  - Response: all outputs are 0 and active_bank = 0 immediately.
  - Follow-up: a full frame after reset release completes normally at addresses 0..11.
